mad_engine: RTL and testbench

//  Median absolute deviation (MAD) engine. It reads an N-sample population from an external sample RAM

---
 rtl/mad_engine_pkg.sv | 17 +
 rtl/mad_engine_if.sv | 13 +
 rtl/mad_engine_rank_select.sv | 59 +++++
 rtl/mad_engine.sv | 165 ++++++++++++++++
 tb/tb_mad_engine.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mad_engine_pkg.sv
// rtl/mad_engine_pkg.sv - shared state encoding and constants for the MAD engine
package madcalc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MED_PASS,
    S_MED_DEC,
    S_DEV_PASS,
    S_DEV_DEC,
    S_SCALE,
    S_DONE
  } mad_state_e;

  localparam int          FRAC_BITS     = 8;
  localparam logic [15:0] SCALE_DEFAULT = 16'h017C;

endpackage

// File: rtl/mad_engine_if.sv
// rtl/mad_engine_if.sv - pipelined sample-RAM read port between the MAD engine and its RAM
interface mad_engine_if #(
  parameter int AW = 7,
  parameter int W  = 8
);
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          rd_vld;

  modport master (output rd_req, output rd_addr, input rd_data, input rd_vld);
  modport slave  (input rd_req, input rd_addr, output rd_data, output rd_vld);
endinterface

// File: rtl/mad_engine_rank_select.sv
// rtl/mad_engine_rank_select.sv - bitwise MSB-first rank selector, one sample pass per result bit
module rank_select #(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init_i,
  input  logic [CW-1:0] k_i,
  input  logic [W-1:0]  sample_i,
  input  logic          sample_vld_i,
  input  logic          decide_i,
  output logic [W-1:0]  result_o,
  output logic          last_bit_o
);
  localparam int BW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  prefix_q;
  logic [CW-1:0] k_q;
  logic [CW-1:0] cnt_q;
  logic [BW-1:0] bit_q;
  logic [W-1:0]  hi_mask;
  logic [W-1:0]  bit_sel;
  logic          match;
  logic          take_one;

  // Only bits above the one under decision take part in the prefix compare.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < W; i++) hi_mask[i] = (i > int'(bit_q));
  end

  assign bit_sel    = W'(1) << bit_q;
  assign match      = (((sample_i ^ prefix_q) & hi_mask) == '0) && !sample_i[bit_q];
  assign take_one   = (k_q >= cnt_q);
  assign result_o   = take_one ? (prefix_q | bit_sel) : prefix_q;
  assign last_bit_o = (bit_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prefix_q <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
    end else if (init_i) begin
      prefix_q <= '0;
      k_q      <= k_i;
      cnt_q    <= '0;
      bit_q    <= BW'(W - 1);
    end else if (decide_i) begin
      prefix_q <= result_o;
      if (take_one) k_q <= k_q - cnt_q;
      cnt_q    <= '0;
      bit_q    <= bit_q - 1'b1;
    end else if (sample_vld_i && match) begin
      cnt_q    <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/mad_engine.sv
// rtl/mad_engine.sv - median / median-absolute-deviation engine over an external sample RAM
// Optional unscaled deviation output enabled by defining MAD_ENGINE_RAW_EN.
module mad_engine
  import madcalc_pkg::*;
#(
  parameter int          POPSIZE    = 100,
  parameter int          DATA_WIDTH = 8,
  parameter logic [15:0] SCALE      = SCALE_DEFAULT,
  localparam int         AW         = $clog2(POPSIZE),
  localparam int         W          = DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [AW:0]            n_len,
  input  logic                   abort,
  mad_engine_if.master           ram,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [W-1:0]           median,
  output logic [W+FRAC_BITS-1:0] mad
`ifdef MAD_ENGINE_RAW_EN
  ,
  output logic [W-1:0]           mad_raw
`endif
);
  mad_state_e             state_q;
  logic [AW:0]            n_q, k0_q, rsp_q, k_new, rs_k;
  logic [AW-1:0]          addr_q;
  logic                   req_q, busy_q, done_q, err_q;
  logic [W-1:0]           med_val_q, dev_q, median_q;
  logic [W-1:0]           abs_diff, sample, rs_result;
  logic [W+FRAC_BITS-1:0] mad_q, dev_ext, scale_ext, mad_next;
  logic                   in_pass, vld, n_ok, last_rsp;
  logic                   rs_init, rs_decide, rs_last;
`ifdef MAD_ENGINE_RAW_EN
  logic [W-1:0]           raw_q;
  assign mad_raw = raw_q;
`endif

  assign k_new     = (n_len - 1'b1) >> 1;
  assign n_ok      = (n_len != '0) && (n_len <= (AW+1)'(POPSIZE));
  assign in_pass   = (state_q == S_MED_PASS) || (state_q == S_DEV_PASS);
  assign vld       = in_pass && ram.rd_vld;
  assign last_rsp  = vld && (rsp_q == n_q - 1'b1);
  assign abs_diff  = (ram.rd_data >= med_val_q) ? ram.rd_data - med_val_q : med_val_q - ram.rd_data;
  assign sample    = (state_q == S_DEV_PASS) ? abs_diff : ram.rd_data;
  assign rs_decide = (state_q == S_MED_DEC) || (state_q == S_DEV_DEC);
  // The selector is re-armed for the deviation phase on the same edge its last median bit lands.
  assign rs_init   = (state_q == S_IDLE && start && !abort && n_ok) || (state_q == S_MED_DEC && rs_last);
  assign rs_k      = (state_q == S_IDLE) ? k_new : k0_q;
  assign dev_ext   = (W+FRAC_BITS)'(dev_q);
  assign scale_ext = (W+FRAC_BITS)'(SCALE);
  assign mad_next  = dev_ext * scale_ext;

  rank_select #(.W(W), .CW(AW+1)) u_rank (
    .clk          (clk),
    .rst          (rst),
    .init_i       (rs_init),
    .k_i          (rs_k),
    .sample_i     (sample),
    .sample_vld_i (vld),
    .decide_i     (rs_decide),
    .result_o     (rs_result),
    .last_bit_o   (rs_last)
  );

  assign ram.rd_req  = req_q;
  assign ram.rd_addr = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign median      = median_q;
  assign mad         = mad_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      k0_q      <= '0;
      rsp_q     <= '0;
      addr_q    <= '0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      med_val_q <= '0;
      dev_q     <= '0;
      median_q  <= '0;
      mad_q     <= '0;
`ifdef MAD_ENGINE_RAW_EN
      raw_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (abort) begin
        state_q <= S_IDLE;
        req_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (start) begin
            if (n_ok) begin
              n_q     <= n_len;
              k0_q    <= k_new;
              addr_q  <= '0;
              req_q   <= 1'b1;
              rsp_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= S_MED_PASS;
            end else begin
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end
          end
          S_MED_PASS, S_DEV_PASS: begin
            if (req_q) begin
              if ({1'b0, addr_q} == n_q - 1'b1) req_q <= 1'b0;
              else addr_q <= addr_q + 1'b1;
            end
            if (vld) rsp_q <= rsp_q + 1'b1;
            if (last_rsp) state_q <= (state_q == S_MED_PASS) ? S_MED_DEC : S_DEV_DEC;
          end
          S_MED_DEC: begin
            rsp_q  <= '0;
            addr_q <= '0;
            req_q  <= 1'b1;
            if (rs_last) begin
              med_val_q <= rs_result;
              state_q   <= S_DEV_PASS;
            end else begin
              state_q   <= S_MED_PASS;
            end
          end
          S_DEV_DEC: begin
            if (rs_last) begin
              dev_q   <= rs_result;
              state_q <= S_SCALE;
            end else begin
              rsp_q   <= '0;
              addr_q  <= '0;
              req_q   <= 1'b1;
              state_q <= S_DEV_PASS;
            end
          end
          S_SCALE: begin
            median_q <= med_val_q;
            mad_q    <= mad_next;
`ifdef MAD_ENGINE_RAW_EN
            raw_q    <= dev_q;
`endif
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_DONE;
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mad_engine.sv
// tb/tb_mad_engine.sv - directed scoreboard bench for mad_engine with a latency-1 RAM model
module tb_mad_engine;
  logic        clk, rst, start, abort;
  logic [7:0]  n_len;
  logic        busy, done, err;
  logic [7:0]  median;
  logic [15:0] mad;
`ifdef MAD_ENGINE_RAW_EN
  logic [7:0]  mad_raw;
`endif

  typedef struct packed {
    logic [7:0]  med;
    logic [15:0] mad;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  last_med = 8'd0;
  logic [15:0] last_mad = 16'd0;
  int          total = 0;
  int          bad = 0;
  logic [7:0]  mem [100];
  int          req_cnt = 0, pass_cnt = 0, addr_bad = 0;
  logic        prev_req = 1'b0;
  logic [6:0]  prev_addr = 7'd0;

  mad_engine_if #(.AW(7), .W(8)) ram ();

  mad_engine #(.POPSIZE(100), .DATA_WIDTH(8), .SCALE(16'h017C)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .n_len  (n_len),
    .abort  (abort),
    .ram    (ram),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .median (median),
`ifdef MAD_ENGINE_RAW_EN
    .mad_raw(mad_raw),
`endif
    .mad    (mad)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM with one cycle of read latency; also tracks the request address stream.
  always @(posedge clk) begin
    ram.rd_vld  <= (ram.rd_req === 1'b1);
    ram.rd_data <= mem[ram.rd_addr];
    if (ram.rd_req === 1'b1) begin
      req_cnt++;
      if (!prev_req) pass_cnt++;
      if (prev_req ? (ram.rd_addr != prev_addr + 7'd1) : (ram.rd_addr != 7'd0)) addr_bad++;
    end
    prev_req  = (ram.rd_req === 1'b1);
    prev_addr = ram.rd_addr;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] lower_med(input logic [7:0] a [100], input int n);
    logic [7:0] s [100];
    logic [7:0] t;
    s = a;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n - 1 - i; j++)
        if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
    return s[(n-1)/2];
  endfunction

  task automatic push_run(input int n);
    logic [7:0] dv [100];
    logic [7:0] m, d;
    exp_t e;
    m  = lower_med(mem, n);
    dv = mem;
    for (int i = 0; i < n; i++) dv[i] = (mem[i] >= m) ? mem[i] - m : m - mem[i];
    d     = lower_med(dv, n);
    e.med = m;
    e.mad = 16'(d) * 16'd380;
    e.err = 1'b0;
    exp_q.push_back(e);
    last_med = m;
    last_mad = e.mad;
  endtask

  task automatic push_err();
    exp_t e;
    e.med = last_med;
    e.mad = last_mad;
    e.err = 1'b1;
    exp_q.push_back(e);
  endtask

  // Called at a negedge with the DUT idle; returns cycles from the start cycle to done.
  task automatic run_and_check(input int n, input int budget, input int poke_at, output int lat);
    exp_t e;
    start = 1'b1;
    n_len = 8'(n);
    lat   = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == poke_at) begin start = 1'b1; n_len = 8'd2; end
      if (done === 1'b1) begin lat = i; break; end
    end
    if (lat < 0) begin
      check("done_seen", {31'b0, done}, 32'd1);
    end else begin
      check("exp_avail", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("median", {24'b0, median}, {24'b0, e.med});
        check("mad", {16'b0, mad}, {16'b0, e.mad});
        check("err", {31'b0, err}, {31'b0, e.err});
      end
      @(negedge clk);
      check("done_pulse", {31'b0, done}, 32'd0);
    end
  endtask

  initial begin
    int lat, r0, p0, a0, seen, n;
    rst = 1'b1; start = 1'b0; abort = 1'b0; n_len = 8'd0;
    for (int i = 0; i < 100; i++) mem[i] = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_req", {31'b0, ram.rd_req}, 32'd0);
    check("rst_addr", {25'b0, ram.rd_addr}, 32'd0);
    check("rst_median", {24'b0, median}, 32'd0);
    check("rst_mad", {16'b0, mad}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd3; mem[3] = 8'd4; mem[4] = 8'd100;
    push_run(5);
    run_and_check(5, 300, 0, lat);
    check("lat_n5", lat, 2*8*(5+2)+2);

    mem[0] = 8'd10; mem[1] = 8'd20; mem[2] = 8'd30; mem[3] = 8'd40;
    push_run(4);
    run_and_check(4, 300, 20, lat);
    check("lat_n4_busy_start", lat, 2*8*(4+2)+2);

    r0 = req_cnt;
    push_err();
    run_and_check(0, 5, 0, lat);
    check("lat_n0", lat, 1);
    push_err();
    run_and_check(101, 5, 0, lat);
    check("lat_n101", lat, 1);
    check("err_no_reads", req_cnt - r0, 0);

    for (int i = 0; i < 100; i++) mem[i] = 8'd255;
    r0 = req_cnt; p0 = pass_cnt; a0 = addr_bad;
    push_run(100);
    run_and_check(100, 2000, 0, lat);
    check("lat_n100", lat, 2*8*(100+2)+2);
    check("sweep_reqs", req_cnt - r0, 1600);
    check("sweep_passes", pass_cnt - p0, 16);
    check("sweep_addr_bad", addr_bad - a0, 0);

    mem[0] = 8'd7; mem[1] = 8'd200; mem[2] = 8'd9; mem[3] = 8'd50; mem[4] = 8'd8;
    start = 1'b1; n_len = 8'd5;
    for (int i = 1; i <= 60; i++) begin @(negedge clk); start = 1'b0; end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_req", {31'b0, ram.rd_req}, 32'd0);
    seen = 0;
    repeat (150) begin @(negedge clk); if (done === 1'b1) seen++; end
    check("abort_no_done", seen, 0);
    push_run(5);
    run_and_check(5, 300, 0, lat);
    check("lat_after_abort", lat, 2*8*(5+2)+2);

    start = 1'b1; abort = 1'b1; n_len = 8'd5;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_wins_busy", {31'b0, busy}, 32'd0);
    check("abort_wins_req", {31'b0, ram.rd_req}, 32'd0);

    start = 1'b1; n_len = 8'd5;
    for (int i = 1; i <= 10; i++) begin @(negedge clk); start = 1'b0; end
    rst = 1'b1;
    #1;
    check("midrst_median", {24'b0, median}, 32'd0);
    check("midrst_mad", {16'b0, mad}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_req", {31'b0, ram.rd_req}, 32'd0);
    check("midrst_addr", {25'b0, ram.rd_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_med = 8'd0; last_mad = 16'd0;
    @(negedge clk);
    push_run(5);
    run_and_check(5, 300, 0, lat);
    check("lat_after_rst", lat, 2*8*(5+2)+2);

    mem[0] = 8'd77;
    push_run(1);
    run_and_check(1, 200, 0, lat);
    check("lat_n1", lat, 2*8*(1+2)+2);

    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(2, 100);
      for (int i = 0; i < 100; i++) mem[i] = 8'($urandom_range(0, (r == 0) ? 15 : 255));
      push_run(n);
      run_and_check(n, 2000, 0, lat);
      check("lat_rand", lat, 2*8*(n+2)+2);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
